// File: rtl/dnc_accelerator_sequencer.sv
// dnc_accelerator_sequencer
// Sequences one inference pass of the DNC accelerator. It streams W (L x X),
// K (R x L x W), B (L) and X (X) from a linear parameter memory into the
// accelerator load ports. It then pulses ACC_START, waits for ACC_READY and
// captures the first Y word.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   START / READY       begin pass (sampled in IDLE) / one-cycle done pulse
//   SIZE_*_IN           tensor dimensions, latched on accepted START
//   MEM_READ/ADDRESS    parameter-memory read strobe and address
//   MEM_DATA            read data, valid one cycle after MEM_READ
//   ACC_START/READY     accelerator start pulse / accelerator done
//   ACC_*_ENABLE        element valid and row/head markers for each tensor
//   ACC_DATA_OUT        element data shared by all load ports
//   ACC_Y_OUT / Y_OUT   accelerator result / captured result word
`timescale 1ns/1ps
module dnc_accelerator_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int ADDRESS_SIZE = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_W_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_R_IN,
  output logic                    MEM_READ,
  output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
  input  logic [DATA_SIZE-1:0]    MEM_DATA,
  output logic                    ACC_START,
  input  logic                    ACC_READY,
  output logic                    ACC_W_IN_L_ENABLE,
  output logic                    ACC_W_IN_X_ENABLE,
  output logic                    ACC_K_IN_I_ENABLE,
  output logic                    ACC_K_IN_L_ENABLE,
  output logic                    ACC_K_IN_K_ENABLE,
  output logic                    ACC_B_IN_ENABLE,
  output logic                    ACC_X_IN_ENABLE,
  output logic [DATA_SIZE-1:0]    ACC_DATA_OUT,
  input  logic [DATA_SIZE-1:0]    ACC_Y_OUT,
  output logic [DATA_SIZE-1:0]    Y_OUT
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_W, S_LOAD_K, S_LOAD_B, S_LOAD_X,
    S_DRAIN, S_RUN, S_WAIT, S_DONE
  } state_t;

  localparam logic [DATA_SIZE-1:0] ONE = DATA_SIZE'(1);

  state_t state, state_nxt;

  logic [DATA_SIZE-1:0] sz_x, sz_l, sz_w, sz_r;
  logic [DATA_SIZE-1:0] ux, ul, uw, ur;  // sizes in effect this cycle
  logic [DATA_SIZE-1:0] c0, c1, c2;      // innermost .. outermost index
  logic [DATA_SIZE-1:0] c0_max;
  logic                 w_ok, k_ok, b_ok, x_ok;
  logic                 c0_wrap, c1_wrap, c2_wrap, last, loading;
  logic                 any_en;
  logic [DATA_SIZE-1:0] data_hold;

  // In IDLE the phase-skip decision must see the sizes being latched now.
  assign ux = (state == S_IDLE) ? SIZE_X_IN : sz_x;
  assign ul = (state == S_IDLE) ? SIZE_L_IN : sz_l;
  assign uw = (state == S_IDLE) ? SIZE_W_IN : sz_w;
  assign ur = (state == S_IDLE) ? SIZE_R_IN : sz_r;

  assign w_ok = (ul != '0) && (ux != '0);
  assign k_ok = (ur != '0) && (ul != '0) && (uw != '0);
  assign b_ok = (ul != '0);
  assign x_ok = (ux != '0);

  // First non-empty phase strictly after cur (IDLE counts as before W).
  function automatic state_t after_phase(state_t cur, logic w, logic k,
                                         logic b, logic x);
    if (cur == S_IDLE && w) return S_LOAD_W;
    if ((cur == S_IDLE || cur == S_LOAD_W) && k) return S_LOAD_K;
    if (cur != S_LOAD_B && cur != S_LOAD_X && b) return S_LOAD_B;
    if (cur != S_LOAD_X && x) return S_LOAD_X;
    return S_DRAIN;
  endfunction

  // Index compares only: each phase ends when every live index hits its max.
  always_comb begin
    case (state)
      S_LOAD_K: c0_max = uw - ONE;
      S_LOAD_B: c0_max = ul - ONE;
      default:  c0_max = ux - ONE;
    endcase
  end

  assign c0_wrap = (c0 == c0_max);
  assign c1_wrap = (c1 == ul - ONE);
  assign c2_wrap = (c2 == ur - ONE);

  always_comb begin
    case (state)
      S_LOAD_W: last = c0_wrap && c1_wrap;
      S_LOAD_K: last = c0_wrap && c1_wrap && c2_wrap;
      S_LOAD_B,
      S_LOAD_X: last = c0_wrap;
      default:  last = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = after_phase(S_IDLE, w_ok, k_ok, b_ok, x_ok);
      S_LOAD_W,
      S_LOAD_K,
      S_LOAD_B,
      S_LOAD_X: if (last) state_nxt = after_phase(state, w_ok, k_ok, b_ok, x_ok);
      S_DRAIN:  state_nxt = S_RUN;
      S_RUN:    state_nxt = S_WAIT;
      S_WAIT:   if (ACC_READY) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    loading   = (state == S_LOAD_W) || (state == S_LOAD_K) ||
                (state == S_LOAD_B) || (state == S_LOAD_X);
    MEM_READ  = loading;
    ACC_START = (state == S_RUN);
    READY     = (state == S_DONE);
  end

  // Sizes, address and nested counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      sz_x <= '0; sz_l <= '0; sz_w <= '0; sz_r <= '0;
      MEM_ADDRESS <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0;
    end else if (state == S_IDLE) begin
      if (START) begin
        sz_x <= SIZE_X_IN; sz_l <= SIZE_L_IN;
        sz_w <= SIZE_W_IN; sz_r <= SIZE_R_IN;
        MEM_ADDRESS <= '0;
      end
      c0 <= '0; c1 <= '0; c2 <= '0;
    end else if (loading) begin
      MEM_ADDRESS <= MEM_ADDRESS + ADDRESS_SIZE'(1);
      if (last) begin
        c0 <= '0; c1 <= '0; c2 <= '0;
      end else if (c0_wrap) begin
        c0 <= '0;
        if (c1_wrap) begin
          c1 <= '0;
          c2 <= c2 + ONE;
        end else begin
          c1 <= c1 + ONE;
        end
      end else begin
        c0 <= c0 + ONE;
      end
    end
  end

  // Enables are registered so they line up with MEM_DATA one cycle later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ACC_W_IN_L_ENABLE <= 1'b0; ACC_W_IN_X_ENABLE <= 1'b0;
      ACC_K_IN_I_ENABLE <= 1'b0; ACC_K_IN_L_ENABLE <= 1'b0;
      ACC_K_IN_K_ENABLE <= 1'b0; ACC_B_IN_ENABLE   <= 1'b0;
      ACC_X_IN_ENABLE   <= 1'b0;
    end else begin
      ACC_W_IN_X_ENABLE <= (state == S_LOAD_W);
      ACC_W_IN_L_ENABLE <= (state == S_LOAD_W) && (c0 == '0);
      ACC_K_IN_K_ENABLE <= (state == S_LOAD_K);
      ACC_K_IN_L_ENABLE <= (state == S_LOAD_K) && (c0 == '0);
      ACC_K_IN_I_ENABLE <= (state == S_LOAD_K) && (c0 == '0) && (c1 == '0);
      ACC_B_IN_ENABLE   <= (state == S_LOAD_B);
      ACC_X_IN_ENABLE   <= (state == S_LOAD_X);
    end
  end

  // Data passes straight through while an element is valid and holds otherwise.
  assign any_en = ACC_W_IN_X_ENABLE | ACC_K_IN_K_ENABLE |
                  ACC_B_IN_ENABLE | ACC_X_IN_ENABLE;
  assign ACC_DATA_OUT = any_en ? MEM_DATA : data_hold;

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_hold <= '0;
      Y_OUT     <= '0;
    end else begin
      if (any_en) data_hold <= MEM_DATA;
      if (state == S_WAIT && ACC_READY) Y_OUT <= ACC_Y_OUT;
    end
  end

endmodule

// File: tb/tb_dnc_accelerator_sequencer.sv
`timescale 1ns/1ps
module tb_dnc_accelerator_sequencer;
  localparam int DS = 64;
  localparam int AS = 16;

  logic          CLK = 1'b0, RST = 1'b1, START = 1'b0;
  logic [DS-1:0] SIZE_X_IN = '0, SIZE_L_IN = '0, SIZE_W_IN = '0, SIZE_R_IN = '0;
  logic          READY, MEM_READ, ACC_START;
  logic [AS-1:0] MEM_ADDRESS;
  logic [DS-1:0] MEM_DATA = '0;
  logic          ACC_READY = 1'b0;
  logic          w_l, w_x, k_i, k_l, k_k, b_en, x_en;
  logic [DS-1:0] ACC_DATA_OUT, Y_OUT;
  logic [DS-1:0] ACC_Y_OUT = '0;

  dnc_accelerator_sequencer #(.DATA_SIZE(DS), .ADDRESS_SIZE(AS)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_X_IN(SIZE_X_IN), .SIZE_L_IN(SIZE_L_IN),
    .SIZE_W_IN(SIZE_W_IN), .SIZE_R_IN(SIZE_R_IN),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_DATA(MEM_DATA),
    .ACC_START(ACC_START), .ACC_READY(ACC_READY),
    .ACC_W_IN_L_ENABLE(w_l), .ACC_W_IN_X_ENABLE(w_x),
    .ACC_K_IN_I_ENABLE(k_i), .ACC_K_IN_L_ENABLE(k_l), .ACC_K_IN_K_ENABLE(k_k),
    .ACC_B_IN_ENABLE(b_en), .ACC_X_IN_ENABLE(x_en),
    .ACC_DATA_OUT(ACC_DATA_OUT), .ACC_Y_OUT(ACC_Y_OUT), .Y_OUT(Y_OUT)
  );

  always #5 CLK = ~CLK;

  // Parameter memory: mem[a] = a + 1, one-cycle read latency.
  always @(posedge CLK) if (MEM_READ) MEM_DATA <= DS'(MEM_ADDRESS) + 64'd1;

  int tests = 0, fails = 0, ready_cnt = 0;

  // Flags: {W_L, W_X, K_I, K_L, K_K, B, X}
  typedef struct packed { logic [6:0] fl; logic [DS-1:0] d; } elem_t;
  elem_t         exp_e[$];
  logic [AS-1:0] exp_a[$];

  task automatic chk(input string nm, input logic [DS-1:0] got, input logic [DS-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read or element.
  logic [6:0]    mon_fl;
  elem_t         mon_e;
  logic [AS-1:0] mon_a;
  always @(negedge CLK) begin
    mon_fl = {w_l, w_x, k_i, k_l, k_k, b_en, x_en};
    if (mon_fl != '0) begin
      if (exp_e.size() == 0) chk("unexpected_element", DS'(mon_fl), '0);
      else begin
        mon_e = exp_e.pop_front();
        chk("elem_flags", DS'(mon_fl), DS'(mon_e.fl));
        chk("elem_data", ACC_DATA_OUT, mon_e.d);
      end
    end
    if (MEM_READ) begin
      if (exp_a.size() == 0) chk("unexpected_read", DS'(MEM_ADDRESS), '1);
      else begin
        mon_a = exp_a.pop_front();
        chk("read_addr", DS'(MEM_ADDRESS), DS'(mon_a));
      end
    end
    if (READY) ready_cnt++;
  end

  // Hand-computed element streams for X=2,L=2,W=1,R=1 (data = address + 1).
  logic [6:0] t1_fl [10] = '{7'b1100000, 7'b0100000, 7'b1100000, 7'b0100000,
                             7'b0011100, 7'b0001100, 7'b0000010, 7'b0000010,
                             7'b0000001, 7'b0000001};
  logic [6:0] t2_fl [8]  = '{7'b1100000, 7'b0100000, 7'b1100000, 7'b0100000,
                             7'b0000010, 7'b0000010, 7'b0000001, 7'b0000001};

  task automatic push_t1();
    for (int i = 0; i < 10; i++) exp_e.push_back('{fl: t1_fl[i], d: DS'(i + 1)});
  endtask

  task automatic push_t2();
    for (int i = 0; i < 8; i++) exp_e.push_back('{fl: t2_fl[i], d: DS'(i + 1)});
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, DS'({READY, MEM_READ, ACC_START, w_l, w_x, k_i, k_l, k_k, b_en, x_en}), '0);
    chk({nm, "_addr"}, DS'(MEM_ADDRESS), '0);
    chk({nm, "_data"}, ACC_DATA_OUT, '0);
    chk({nm, "_y"}, Y_OUT, '0);
  endtask

  // One pass. START is driven in cycle -1; cycle k is observed at its negedge.
  task automatic run_pass(input logic [DS-1:0] x, l, w, r, input int nreads,
                          input int wt, input int bogus, input bit hold,
                          input logic [DS-1:0] y);
    int k, rc0;
    for (int a = 0; a < nreads; a++) exp_a.push_back(AS'(a));
    rc0 = ready_cnt;
    SIZE_X_IN = x; SIZE_L_IN = l; SIZE_W_IN = w; SIZE_R_IN = r;
    START = 1'b1;
    for (k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (ACC_START) break;
      START     = hold && (k >= 4);
      ACC_READY = (k == bogus);
    end
    ACC_READY = 1'b0;
    chk("acc_start_latency", DS'(k + 1), DS'(nreads + 2));
    repeat (wt - 1) @(negedge CLK);
    @(negedge CLK);
    ACC_READY = 1'b1; ACC_Y_OUT = y;
    @(negedge CLK);
    chk("ready_pulse", DS'(READY), 64'd1);
    chk("y_capture", Y_OUT, y);
    ACC_READY = 1'b0; START = 1'b0; ACC_Y_OUT = '0;
    @(negedge CLK);
    chk("ready_one_cycle", DS'(READY), 64'd0);
    chk("y_hold", Y_OUT, y);
    repeat (2) @(negedge CLK);
    chk("ready_count", DS'(ready_cnt - rc0), 64'd1);
    chk("elem_queue_drained", DS'(exp_e.size()), '0);
    chk("addr_queue_drained", DS'(exp_a.size()), '0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_all_zero("reset_state");

    // Full pass
    push_t1();
    run_pass(2, 2, 1, 1, 10, 5, -1, 0, 64'hABCD);

    // Empty K phase
    push_t2();
    run_pass(2, 2, 1, 0, 8, 5, -1, 0, 64'h1234);

    // All sizes zero
    run_pass(0, 0, 0, 0, 0, 3, -1, 0, 64'h5555);

    // START re-asserted from LOAD_K through WAIT
    push_t1();
    run_pass(2, 2, 1, 1, 10, 4, -1, 1, 64'h7777);

    // Reset mid LOAD_W: reads 0,1 and the first element, then abort.
    exp_a.push_back(AS'(0)); exp_a.push_back(AS'(1));
    exp_e.push_back('{fl: 7'b1100000, d: 64'd1});
    SIZE_X_IN = 2; SIZE_L_IN = 2; SIZE_W_IN = 1; SIZE_R_IN = 1;
    START = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);
    chk_all_zero("mid_pass_reset");
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_no_ready", DS'(ready_cnt), 64'd4);
    chk("reset_queues", DS'(exp_e.size() + exp_a.size()), '0);

    // Restart after reset begins again at address 0
    push_t1();
    run_pass(2, 2, 1, 1, 10, 5, -1, 0, 64'h2468);

    // ACC_READY pulsed in LOAD_B is ignored
    push_t1();
    run_pass(2, 2, 1, 1, 10, 6, 6, 0, 64'h9999);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dnc_accelerator_sequencer.md
Name: dnc_accelerator_sequencer

Overview:
Controller that sequences one inference pass of the DNC accelerator top. On START it streams the weight tensors W (L×X) and K (R×L×W), then bias B (L), then input X (X) from a linear parameter memory into the accelerator's load ports. It then pulses the accelerator start, waits for its ready, and captures the first Y output word. It sits between the MPSoC-side parameter RAM and the accelerator top, replacing bench stimulus in system use.

Parameters:
DATA_SIZE, 64, width of data words and size/counter registers
ADDRESS_SIZE, 16, width of parameter-memory address; addresses wrap modulo 2^ADDRESS_SIZE

Ports:
CLK  input  1  clock
RST  input  1  reset; synchronous and active-high
START  input  1  begin pass; sampled only in IDLE
READY  output  1  one-cycle pulse when the pass completes
SIZE_X_IN, SIZE_L_IN, SIZE_W_IN, SIZE_R_IN  input  DATA_SIZE each  tensor dimensions, latched on accepted START
MEM_READ  output  1  parameter-memory read strobe
MEM_ADDRESS  output  ADDRESS_SIZE  read address
MEM_DATA  input  DATA_SIZE  read data, valid exactly 1 cycle after MEM_READ
ACC_START  output  1  one-cycle start pulse to accelerator
ACC_READY  input  1  accelerator done
ACC_W_IN_L_ENABLE, ACC_W_IN_X_ENABLE  output  1 each  W row start / W element valid
ACC_K_IN_I_ENABLE, ACC_K_IN_L_ENABLE, ACC_K_IN_K_ENABLE  output  1 each  K head / row / element valid
ACC_B_IN_ENABLE  output  1  B element valid
ACC_X_IN_ENABLE  output  1  X element valid
ACC_DATA_OUT  output  DATA_SIZE  element data, shared by W/K/B/X loads
ACC_Y_OUT  input  DATA_SIZE  accelerator result
Y_OUT  output  DATA_SIZE  captured result word

Behaviour:
- Reset:
  - All outputs 0; state IDLE; counters and MEM_ADDRESS 0.
  - Reset asserted in any state aborts the pass; no READY is issued for the aborted pass.
- States: IDLE → LOAD_W → LOAD_K → LOAD_B → LOAD_X → DRAIN → RUN → WAIT → DONE → IDLE.
- IDLE:
  - START=1 latches the four sizes and clears the address to 0; next state LOAD_W.
  - START in any other state is ignored.
- Load phases:
  - Each cycle in a phase issues MEM_READ=1 at the current MEM_ADDRESS; the address then increments by 1 (single linear address across all phases).
  - Layout in memory: W row-major (l outer, x inner), then K (i outer over R, l, k inner over W), then B, then X.
  - Counters advance innermost first. The phase ends on the cycle its last element is read.
  - Empty phase: if any dimension of a phase is 0, that phase issues no reads and is skipped in 0 cycles. Sizes are compared as unsigned DATA_SIZE values.
- Element timing:
  - The element read at cycle t is presented at t+1: ACC_DATA_OUT=MEM_DATA, with the phase's element enable (W_X, K_K, B, X) high for exactly that cycle.
  - Row/head markers are asserted in the same cycle as the first element they cover:
    - ACC_W_IN_L_ENABLE when x index was 0.
    - ACC_K_IN_L_ENABLE when k index was 0.
    - ACC_K_IN_I_ENABLE when both l and k indices were 0.
  - Enables are registered; ACC_DATA_OUT holds its last value when no enable is high.
  - Consecutive elements stream back-to-back with no bubbles, including across phase boundaries.
- DRAIN: one cycle to present the final read element.
- RUN: ACC_START=1 for one cycle, then WAIT.
- WAIT:
  - Stays in WAIT until ACC_READY=1; on that cycle Y_OUT<=ACC_Y_OUT, then DONE.
  - ACC_READY is ignored in every other state.
- DONE: READY=1 for one cycle, then IDLE. Y_OUT holds until the next capture or reset.
- Total reads per pass = L·X + R·L·W + L + X. Cycles from accepted START to ACC_START = reads + 2.
- Counter products are never computed; only nested index compares are used, so no multiplier is required.

Test Plan:
- X=2,L=2,W=1,R=1: mem[i]=i+1.
  - Required: reads at addresses 0..9.
  - W_X enable with data 1,2,3,4; W_L enable on data 1 and 3.
  - K_K enable on data 5,6; K_I on 5; K_L on 5 and 6.
  - B on 7,8; X on 9,10.
  - ACC_START 12 cycles after START; ACC_READY after 5 cycles with ACC_Y_OUT=0xABCD gives Y_OUT=0xABCD and READY the following cycle.
- R=0, others as above: no K enables, 8 reads (0..7), and ACC_START 10 cycles after START.
- All sizes 0: no MEM_READ, ACC_START 2 cycles after START, and READY after ACC_READY.
- START re-asserted during LOAD_K and held high through WAIT: the pass is unchanged and exactly one READY is issued.
- RST asserted mid-LOAD_W: the next cycle has all outputs 0 and state IDLE. A subsequent START restarts from address 0.
- ACC_READY pulsed during LOAD_B: ignored. Completion only after ACC_READY arrives in WAIT.
